// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared arbiter state/owner enums and default parameter constants
package mem_arb_pkg;
  localparam int ADDR_W_DEF     = 64;
  localparam int DATA_W_DEF     = 64;
  localparam int STARVE_MAX_DEF = 4;
  typedef enum logic [1:0] {IDLE, REQ, RESP} t_arb_state;
  typedef enum logic [1:0] {NONE, IF, MEM} t_owner;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and load/store (MEM) requesters with starvation guard; ports: i_clk/i_rst, IF req/addr, MEM req/we/addr/wdata/wstrb, done pulses, rdata, stall, shared port request/response
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_mem_req,
  input  logic                i_mem_we,
  input  logic [ADDR_W-1:0]   i_mem_addr,
  input  logic [DATA_W-1:0]   i_mem_wdata,
  input  logic [DATA_W/8-1:0] i_mem_wstrb,
  output logic                o_if_done,
  output logic                o_mem_done,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_stall,
  output logic                o_port_valid,
  output logic                o_port_we,
  output logic [ADDR_W-1:0]   o_port_addr,
  output logic [DATA_W-1:0]   o_port_wdata,
  output logic [DATA_W/8-1:0] o_port_wstrb,
  input  logic                i_port_ready,
  input  logic                i_port_rvalid,
  input  logic [DATA_W-1:0]   i_port_rdata
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  t_arb_state          state;
  t_owner              owner;
  logic [CW-1:0]       starve;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                mem_win;
  logic                resp_done;
  logic [CW-1:0]       starve_inc;
  assign mem_win    = i_mem_req && (starve < CW'(STARVE_MAX));
  assign starve_inc = (starve == CW'(STARVE_MAX)) ? starve : starve + 1'b1;
  // reset abandons an in-flight response, so completion is masked by i_rst
  assign resp_done    = (state == RESP) && i_port_rvalid && !i_rst;
  assign o_if_done    = resp_done && (owner == IF);
  assign o_mem_done   = resp_done && (owner == MEM);
  assign o_rdata      = resp_done ? i_port_rdata : '0;
  assign o_stall      = (i_if_req && !o_if_done) || (i_mem_req && !o_mem_done);
  assign o_port_valid = (state == REQ) && !i_rst;
  assign o_port_we    = we_q && !i_rst;
  assign o_port_addr  = addr_q;
  assign o_port_wdata = wdata_q;
  assign o_port_wstrb = wstrb_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      owner   <= NONE;
      starve  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_win) begin
            state   <= REQ;
            owner   <= MEM;
            we_q    <= i_mem_we;
            addr_q  <= i_mem_addr;
            wdata_q <= i_mem_wdata;
            wstrb_q <= i_mem_wstrb;
            starve  <= i_if_req ? starve_inc : '0;
          end else if (i_if_req) begin
            state   <= REQ;
            owner   <= IF;
            we_q    <= 1'b0;
            addr_q  <= i_if_addr;
            wdata_q <= '0;
            wstrb_q <= '0;
            starve  <= '0;
          end else begin
            starve  <= '0;
          end
        end
        REQ:  state <= i_port_ready ? RESP : REQ;
        RESP: begin
          if (i_port_rvalid) begin
            state <= IDLE;
            owner <= NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized run against a transaction-level reference model
module tb_mem_port_arbiter;
  localparam int SMAX = 4;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, port_ready, port_rvalid;
  logic [63:0] if_addr, mem_addr, mem_wdata, port_rdata;
  logic [7:0]  mem_wstrb;
  logic        if_done, mem_done, stall, port_valid, port_we;
  logic [63:0] rdata, port_addr, port_wdata;
  logic [7:0]  port_wstrb;
  int tests = 0;
  int fails = 0;
  mem_port_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr),
    .i_mem_wdata(mem_wdata), .i_mem_wstrb(mem_wstrb),
    .o_if_done(if_done), .o_mem_done(mem_done), .o_rdata(rdata), .o_stall(stall),
    .o_port_valid(port_valid), .o_port_we(port_we), .o_port_addr(port_addr),
    .o_port_wdata(port_wdata), .o_port_wstrb(port_wstrb),
    .i_port_ready(port_ready), .i_port_rvalid(port_rvalid), .i_port_rdata(port_rdata)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(negedge clk);
  endtask
  task automatic idle_inputs;
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0;
    mem_wdata = '0; mem_wstrb = '0; port_ready = 0; port_rvalid = 0; port_rdata = '0;
  endtask
  task automatic do_reset;
    step; idle_inputs; rst = 1;
    step; rst = 0;
  endtask
  task automatic test_reset;
    step; rst = 1; if_req = 1; mem_req = 1; mem_we = 1; #1;
    tests++; if (port_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", port_valid); end
    tests++; if ({if_done, mem_done} !== 2'b00) begin fails++; $display("FAIL rst_done: got %b want 00", {if_done, mem_done}); end
    tests++; if (port_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", port_we); end
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rst_stall: got %b want 1", stall); end
    step; #1;
    step; rst = 0; if_req = 0; mem_req = 0; mem_we = 0; #1;
    tests++; if (port_addr !== 64'h0 || port_wstrb !== 8'h0 || port_wdata !== 64'h0) begin fails++; $display("FAIL rst_fields: got %h %h %h want 0", port_addr, port_wstrb, port_wdata); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall_idle: got %b want 0", stall); end
    step; #1;
    tests++; if (port_valid !== 1'b0) begin fails++; $display("FAIL rst_idle_valid: got %b want 0", port_valid); end
  endtask
  task automatic test_lone_fetch;
    step; if_req = 1; if_addr = 64'h1000; port_ready = 1; #1;
    tests++; if (port_valid !== 1'b0) begin fails++; $display("FAIL lf_c0_valid: got %b want 0", port_valid); end
    step; #1;
    tests++; if (port_valid !== 1'b1) begin fails++; $display("FAIL lf_c1_valid: got %b want 1", port_valid); end
    tests++; if (port_addr !== 64'h1000 || port_we !== 1'b0 || port_wstrb !== 8'h0) begin fails++; $display("FAIL lf_c1_fields: got %h %b %h want 1000 0 00", port_addr, port_we, port_wstrb); end
    step; port_ready = 0; #1;
    tests++; if (port_valid !== 1'b0 || if_done !== 1'b0) begin fails++; $display("FAIL lf_c2: got valid %b done %b want 0 0", port_valid, if_done); end
    step; #1;
    tests++; if (if_done !== 1'b0 || stall !== 1'b1) begin fails++; $display("FAIL lf_c3: got done %b stall %b want 0 1", if_done, stall); end
    step; port_rvalid = 1; port_rdata = 64'hDEAD; #1;
    tests++; if (if_done !== 1'b1 || mem_done !== 1'b0) begin fails++; $display("FAIL lf_c4_done: got %b%b want 10", if_done, mem_done); end
    tests++; if (rdata !== 64'hDEAD) begin fails++; $display("FAIL lf_c4_rdata: got %h want dead", rdata); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lf_c4_stall: got %b want 0", stall); end
    step; port_rvalid = 0; if_req = 0; #1;
    tests++; if (if_done !== 1'b0) begin fails++; $display("FAIL lf_c5_done: got %b want 0", if_done); end
    step; #1;
    tests++; if (port_valid !== 1'b0) begin fails++; $display("FAIL lf_c6_valid: got %b want 0", port_valid); end
  endtask
  task automatic test_both;
    int order[$];
    int mk = -10;
    bit got_if = 0;
    bit drop_mem = 0;
    step; if_req = 1; if_addr = 64'h2000; mem_req = 1; mem_we = 0; mem_addr = 64'h3000;
    port_ready = 1; port_rvalid = 1;
    for (int k = 0; k < 20 && !got_if; k++) begin
      if (k > 0) step;
      if (drop_mem) mem_req = 0;
      #1;
      tests++; if (stall !== !if_done) begin fails++; $display("FAIL both_stall k=%0d: got %b want %b", k, stall, !if_done); end
      if (k == mk + 1) begin tests++; if (port_valid !== 1'b0) begin fails++; $display("FAIL both_gap: got %b want 0", port_valid); end end
      if (k == mk + 2) begin tests++; if (port_valid !== 1'b1 || port_addr !== 64'h2000) begin fails++; $display("FAIL both_if_grant: got %b %h want 1 2000", port_valid, port_addr); end end
      if (mem_done) begin order.push_back(2); drop_mem = 1; mk = k; end
      if (if_done) begin order.push_back(1); got_if = 1; end
    end
    tests++; if (!got_if) begin fails++; $display("FAIL both_timeout: got no if_done want if_done"); end
    tests++; if (order.size() != 2 || order[0] != 2 || order[1] != 1) begin fails++; $display("FAIL both_order: got %p want '{2,1}", order); end
    step; idle_inputs;
  endtask
  task automatic test_store;
    int vcnt = 0;
    logic [63:0] wd;
    wd = {$urandom, $urandom};
    step; mem_req = 1; mem_we = 1; mem_addr = 64'h40; mem_wdata = wd; mem_wstrb = 8'h0F; #1;
    for (int k = 0; k < 20; k++) begin
      step; port_ready = port_valid && vcnt == 3; #1;
      if (!port_valid && vcnt > 0) break;
      if (port_valid) begin
        vcnt++;
        tests++; if (port_we !== 1'b1 || port_addr !== 64'h40 || port_wdata !== wd || port_wstrb !== 8'h0F) begin fails++; $display("FAIL st_fields: got %b %h %h %h want 1 40 %h 0f", port_we, port_addr, port_wdata, port_wstrb, wd); end
      end
    end
    tests++; if (vcnt != 4) begin fails++; $display("FAIL st_valid_cycles: got %0d want 4", vcnt); end
    port_ready = 0; port_rvalid = 1; #1;
    tests++; if (mem_done !== 1'b1 || if_done !== 1'b0) begin fails++; $display("FAIL st_done: got %b%b want 01", if_done, mem_done); end
    step; idle_inputs;
  endtask
  task automatic test_starve;
    int order[$];
    int exp_o[6] = '{2, 2, 2, 2, 1, 2};
    bit drop_if = 0;
    step; mem_req = 1; if_req = 1; if_addr = 64'h7000; mem_addr = 64'h8000; port_ready = 1; port_rvalid = 1;
    for (int k = 0; k < 40 && order.size() < 6; k++) begin
      if (k > 0) step;
      if (drop_if) if_req = 0;
      #1;
      if (mem_done) order.push_back(2);
      if (if_done) begin order.push_back(1); drop_if = 1; end
    end
    tests++; if (order.size() != 6) begin fails++; $display("FAIL starve_timeout: got %0d grants want 6", order.size()); end
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      tests++; if (order[i] != exp_o[i]) begin fails++; $display("FAIL starve_seq[%0d]: got %0d want %0d", i, order[i], exp_o[i]); end
    end
    step; idle_inputs;
  endtask
  task automatic test_reset_resp;
    step; if_req = 1; if_addr = 64'h5000; port_ready = 1; #1;
    step; #1;
    tests++; if (port_valid !== 1'b1) begin fails++; $display("FAIL rr_valid: got %b want 1", port_valid); end
    step; port_ready = 0; rst = 1; #1;
    tests++; if (port_valid !== 1'b0 || if_done !== 1'b0 || stall !== 1'b1) begin fails++; $display("FAIL rr_in_rst: got %b %b %b want 0 0 1", port_valid, if_done, stall); end
    step; rst = 0; port_rvalid = 1; port_rdata = 64'h1234; #1;
    tests++; if (if_done !== 1'b0 || mem_done !== 1'b0) begin fails++; $display("FAIL rr_late_rvalid: got %b%b want 00", if_done, mem_done); end
    step; port_rvalid = 0; port_ready = 1; #1;
    tests++; if (port_valid !== 1'b1 || port_addr !== 64'h5000) begin fails++; $display("FAIL rr_regrant: got %b %h want 1 5000", port_valid, port_addr); end
    step; port_ready = 0; port_rvalid = 1; port_rdata = 64'h5555; #1;
    tests++; if (if_done !== 1'b1 || rdata !== 64'h5555) begin fails++; $display("FAIL rr_done: got %b %h want 1 5555", if_done, rdata); end
    step; idle_inputs;
  endtask
  task automatic test_spurious;
    step; port_rvalid = 1; port_ready = 1; #1;
    tests++; if ({if_done, mem_done} !== 2'b00) begin fails++; $display("FAIL sp_idle_done: got %b want 00", {if_done, mem_done}); end
    step; #1;
    tests++; if (port_valid !== 1'b0 || {if_done, mem_done} !== 2'b00) begin fails++; $display("FAIL sp_idle_state: got %b %b want 0 00", port_valid, {if_done, mem_done}); end
    step; port_rvalid = 0; if_req = 1; if_addr = 64'h6000; #1;
    step; #1;
    tests++; if (port_valid !== 1'b1) begin fails++; $display("FAIL sp_req: got %b want 1", port_valid); end
    step; #1;
    tests++; if (port_valid !== 1'b0 || if_done !== 1'b0) begin fails++; $display("FAIL sp_resp1: got %b %b want 0 0", port_valid, if_done); end
    step; #1;
    tests++; if (port_valid !== 1'b0 || if_done !== 1'b0) begin fails++; $display("FAIL sp_resp2: got %b %b want 0 0", port_valid, if_done); end
    step; port_ready = 0; port_rvalid = 1; port_rdata = 64'h66; #1;
    tests++; if (if_done !== 1'b1 || rdata !== 64'h66) begin fails++; $display("FAIL sp_done: got %b %h want 1 66", if_done, rdata); end
    step; idle_inputs;
  endtask
  task automatic test_random(input int n);
    int phase = 0;
    int own = 0;
    int starve = 0;
    int cnt = 0;
    bit busy = 0;
    bit drop_if = 0;
    bit drop_mem = 0;
    bit e_ifd, e_md, e_stall;
    logic        e_we;
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_wstrb;
    for (int c = 0; c < n; c++) begin
      step;
      if (drop_if) if_req = 0;
      if (drop_mem) mem_req = 0;
      drop_if = 0; drop_mem = 0;
      if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1; if_addr = {$urandom, $urandom}; end
      if (!mem_req && $urandom_range(0, 2) == 0) begin
        mem_req = 1; mem_we = 1'($urandom); mem_addr = {$urandom, $urandom};
        mem_wdata = {$urandom, $urandom}; mem_wstrb = 8'($urandom);
      end
      port_ready = 1'($urandom);
      port_rdata = {$urandom, $urandom};
      if (busy) begin port_rvalid = (cnt == 0); if (cnt > 0) cnt--; end
      else port_rvalid = ($urandom_range(0, 7) == 0);
      #1;
      e_ifd = phase == 2 && port_rvalid && own == 1;
      e_md = phase == 2 && port_rvalid && own == 2;
      e_stall = (if_req && !e_ifd) || (mem_req && !e_md);
      tests++; if (port_valid !== (phase == 1)) begin fails++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, port_valid, phase == 1); end
      tests++; if (if_done !== e_ifd || mem_done !== e_md) begin fails++; $display("FAIL rnd_done c=%0d: got %b%b want %b%b", c, if_done, mem_done, e_ifd, e_md); end
      tests++; if (stall !== e_stall) begin fails++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, stall, e_stall); end
      if (e_ifd || e_md) begin tests++; if (rdata !== port_rdata) begin fails++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, rdata, port_rdata); end end
      if (phase == 1) begin
        tests++; if (port_addr !== e_addr || port_we !== e_we || port_wstrb !== e_wstrb) begin fails++; $display("FAIL rnd_fields c=%0d: got %h %b %h want %h %b %h", c, port_addr, port_we, port_wstrb, e_addr, e_we, e_wstrb); end
        if (own == 2) begin tests++; if (port_wdata !== e_wdata) begin fails++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, port_wdata, e_wdata); end end
      end
      if (busy && port_rvalid) busy = 0;
      if (port_valid && port_ready) begin busy = 1; cnt = $urandom_range(0, 3); end
      if (e_ifd) drop_if = 1;
      if (e_md) drop_mem = 1;
      if (phase == 0) begin
        if (mem_req && starve < SMAX) begin
          phase = 1; own = 2; e_we = mem_we; e_addr = mem_addr; e_wdata = mem_wdata; e_wstrb = mem_wstrb;
          starve = if_req ? (starve + 1 > SMAX ? SMAX : starve + 1) : 0;
        end else if (if_req) begin
          phase = 1; own = 1; e_we = 0; e_addr = if_addr; e_wstrb = '0; starve = 0;
        end else starve = 0;
      end else if (phase == 1) begin
        if (port_ready) phase = 2;
      end else if (port_rvalid) begin
        phase = 0; own = 0;
      end
    end
    step; idle_inputs;
  endtask
  initial begin
    rst = 0;
    idle_inputs;
    test_reset;
    do_reset; test_lone_fetch;
    do_reset; test_both;
    do_reset; test_store;
    do_reset; test_starve;
    do_reset; test_reset_resp;
    do_reset; test_spurious;
    do_reset; test_random(600);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 64, address width.
REQ-002 Parameter DATA_W, 64, data width; strobe width is DATA_W/8.
REQ-003 Parameter STARVE_MAX, 4, max consecutive data grants while fetch waits.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_if_req  in  1  fetch request, held until o_if_done.
REQ-007 i_if_addr  in  ADDR_W  fetch address.
REQ-008 i_mem_req  in  1  load/store request (decoder mem_access), held until o_mem_done.
REQ-009 i_mem_we  in  1  1 = store, 0 = load.
REQ-010 i_mem_addr / i_mem_wdata / i_mem_wstrb  in  ADDR_W / DATA_W / DATA_W/8  data-side fields.
REQ-011 o_if_done / o_mem_done  out  1  one-cycle completion pulse per requester.
REQ-012 o_rdata  out  DATA_W  read data, valid only while a done pulse is high.
REQ-013 o_stall  out  1  pipeline stall = (i_if_req & ~o_if_done) | (i_mem_req & ~o_mem_done).
REQ-014 o_port_valid / o_port_we / o_port_addr / o_port_wdata / o_port_wstrb  out  shared memory-port request.
REQ-015 i_port_ready  in  1  port accepts request.
REQ-016 i_port_rvalid / i_port_rdata  in  1 / DATA_W  port response; rvalid also acknowledges stores.

Function
REQ-017 FSM SHALL have states IDLE, REQ, RESP plus registered owner (NONE/IF/MEM).
REQ-018 IDLE: mem_req and starve count < STARVE_MAX -> owner MEM; else if_req -> owner IF; else stay IDLE.
REQ-019 On grant, request fields SHALL be latched into registers; next state REQ (o_port_valid rises 1 cycle after request seen).
REQ-020 REQ: o_port_valid = 1, latched fields stable; on i_port_ready -> RESP.
REQ-021 RESP: o_port_valid = 0; on i_port_rvalid, owner's done pulses combinationally same cycle, o_rdata = i_port_rdata; next state IDLE.
REQ-022 IF grants force o_port_we = 0 and o_port_wstrb = 0.
REQ-023 i_port_rvalid outside RESP and i_port_ready outside REQ SHALL be ignored.
REQ-024 Starve counter increments (saturating at STARVE_MAX) on each MEM grant while i_if_req = 1, clears on IF grant or when i_if_req = 0 in IDLE.
REQ-025 If both requests are present and count = STARVE_MAX, IF is granted.
REQ-026 A requester dropping req mid-transaction SHALL NOT abort it; done still pulses.
REQ-027 No more than one outstanding port transaction at any time; back-to-back grants have at least one IDLE cycle.
REQ-028 Done pulses are never asserted for both requesters in the same cycle.

Reset
REQ-029 On i_rst: state IDLE, owner NONE, starve count 0, latched fields 0.
REQ-030 During reset, o_port_valid, o_if_done, o_mem_done, o_port_we are 0; o_stall still follows REQ-013.
REQ-031 Reset mid-transaction abandons it with no done pulse; the port is reset together with the arbiter.

Structure
REQ-032 Shared package mem_arb_pkg SHALL hold t_arb_state (IDLE, REQ, RESP), t_owner (NONE, IF, MEM) and default parameter constants.
REQ-033 Single module, no sub-module; the starve counter is inline.

Verification
REQ-034 Lone fetch: if_req = 1, addr 0x1000, ready same cycle, rvalid 2 cycles later with 0xDEAD -> o_port_valid at cycle 1, o_if_done at cycle 4, o_rdata = 0xDEAD.
REQ-035 Simultaneous fetch and load, both held -> MEM granted first, IF granted after IDLE cycle; stall stays high until second done.
REQ-036 Store with wstrb 0x0F, ready delayed 3 cycles -> o_port_valid held 4 cycles with stable fields; done on ack.
REQ-037 Continuous mem_req plus if_req, STARVE_MAX = 4 -> grant sequence MEM×4, IF, then MEM resumes.
REQ-038 i_rst asserted in RESP, then rvalid arrives -> no done pulse; state IDLE; next request served normally.
REQ-039 Spurious rvalid in IDLE and ready in RESP -> no done, no state change.
